// File: rtl/data_mem_if_if.sv
// Word-wide data bus between the core's memory interface and a memory slave.
// The master issues single-beat accesses; the slave answers with ready and read data.
interface data_mem_if_if;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_be,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_be,
        output bus_ready,
        output bus_rdata
    );
endinterface

// File: rtl/data_mem_if.sv
// Core data-memory interface: turns load/store requests into single-beat word
// bus accesses with byte lanes, misalignment detection and a bus timeout.
module data_mem_if #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [1:0]    req_size,
    output logic          stall,
    output logic [31:0]   rdata,
    output logic          misalign_err,
    output logic          bus_err,
    data_mem_if_if.master mem
);
    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [31:0]      rdata_d;
    logic             misalign_err_d, bus_err_d;

    logic             valid_q, valid_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;

    logic             misaligned;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;

    // Size decode: alignment check, byte-lane enables and lane-replicated store data
    always_comb begin
        misaligned = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                lane_be    = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = (req_addr[1:0] != 2'b00);
                lane_be    = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        rdata_d        = rdata;
        misalign_err_d = 1'b0;
        bus_err_d      = 1'b0;
        valid_d        = valid_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_d        = ERR;
                        misalign_err_d = 1'b1;
                    end else begin
                        state_d = BUS;
                        valid_d = 1'b1;
                        we_d    = req_we;
                        addr_d  = {req_addr[31:2], 2'b00};
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                        cnt_d   = '0;
                    end
                end
            end
            BUS: begin
                // A ready in the final wait cycle still completes the access cleanly
                if (mem.bus_ready) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem.bus_rdata;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_d   = DONE;
                    valid_d   = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides every transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rdata        <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            valid_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            rdata        <= rdata_d;
            misalign_err <= misalign_err_d;
            bus_err      <= bus_err_d;
            valid_q      <= valid_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    // The core is released in the single-cycle completion states
    assign stall = req_valid && (state != DONE) && (state != ERR);

    assign mem.bus_valid = valid_q;
    assign mem.bus_we    = we_q;
    assign mem.bus_addr  = addr_q;
    assign mem.bus_wdata = wdata_q;
    assign mem.bus_be    = be_q;
endmodule

// File: tb/tb_data_mem_if.sv
// Randomized scoreboard bench for data_mem_if: a driver issues core requests,
// a slave model answers the bus, and a monitor checks completions and bus cycles.
module tb_data_mem_if;
    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign_err;
    logic        bus_err;

    data_mem_if_if mem ();

    data_mem_if #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .stall        (stall),
        .rdata        (rdata),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .mem          (mem)
    );

    typedef struct {
        bit          err;
        bit          timeout;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          bus_cycles;
    } exp_t;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
    } slv_t;

    exp_t        exp_q[$];
    slv_t        slv_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] model_rdata = 32'h0;
    int          bus_run = 0;
    int          stall_run = 0;
    exp_t        cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, expv);
        end
    endtask

    // Reference model: derive the expected bus access and core response from the request
    task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] brdata);
        exp_t e;
        slv_t s;
        int   nb;
        int   guard;
        nb        = 1 << size;
        e.err     = (size == 2'd3) || ((addr & 32'(nb - 1)) != 32'h0);
        e.we      = we;
        e.addr    = addr & 32'hFFFF_FFFC;
        e.be      = 4'(((1 << nb) - 1) << addr[1:0]);
        e.wdata   = 32'h0;
        if (!e.err) begin
            for (int i = 0; i < 4; i++) e.wdata[i*8 +: 8] = wdata[(i % nb)*8 +: 8];
        end
        e.timeout    = !e.err && (waits >= int'(TIMEOUT));
        e.bus_cycles = e.err ? 0 : (e.timeout ? int'(TIMEOUT) : waits + 1);
        if (e.timeout)              e.rdata = 32'h0;
        else if (e.err || we)       e.rdata = model_rdata;
        else                        e.rdata = brdata;
        model_rdata = e.rdata;
        if (!e.err) begin
            s.waits = waits;
            s.rdata = brdata;
            slv_q.push_back(s);
        end
        exp_q.push_back(e);

        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        guard = 0;
        // Request fields are scrambled after sampling; the DUT must ignore them
        while (stall && guard < 64) begin
            req_we    = 1'($urandom_range(0, 1));
            req_size  = 2'($urandom_range(0, 3));
            req_addr  = $urandom;
            req_wdata = $urandom;
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 64) begin
            errors++;
            $display("FAIL release: stall still %0b after %0d cycles, required 0", stall, guard);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_gap(input int n);
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_size  = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        req_wdata = $urandom;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Bus slave: answers each access after its configured number of wait cycles
    initial begin
        int   cyc;
        slv_t sc;
        cyc           = 0;
        sc.waits      = 1000;
        sc.rdata      = 32'h0;
        mem.bus_ready = 1'b0;
        mem.bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem.bus_valid === 1'b1) begin
                if (cyc == 0) begin
                    if (slv_q.size() > 0) sc = slv_q.pop_front();
                    else begin
                        sc.waits = 1000;
                        sc.rdata = 32'h0;
                    end
                end
                mem.bus_ready = (cyc == sc.waits);
                mem.bus_rdata = (cyc == sc.waits) ? sc.rdata : $urandom;
                cyc++;
            end else begin
                cyc           = 0;
                mem.bus_ready = 1'($urandom_range(0, 1));
                mem.bus_rdata = $urandom;
            end
        end
    end

    // Monitor: checks bus cycles against the head expectation and pops on completion
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                bus_run   = 0;
                stall_run = 0;
            end else begin
                if (mem.bus_valid !== 1'b0) begin
                    bus_run++;
                    if (exp_q.size() == 0) begin
                        chk("bus_valid_unexpected", 32'(mem.bus_valid), 32'h0);
                    end else begin
                        cur = exp_q[0];
                        chk("bus_valid_on_misaligned", 32'(mem.bus_valid), 32'(!cur.err));
                        chk("bus_we", 32'(mem.bus_we), 32'(cur.we));
                        chk("bus_addr", mem.bus_addr, cur.addr);
                        chk("bus_be", 32'(mem.bus_be), 32'(cur.be));
                        chk("bus_wdata", mem.bus_wdata, cur.wdata);
                    end
                end
                if (req_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        chk("completion_unexpected", 32'(stall), 32'h1);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("stall_cycles", 32'(stall_run), 32'(cur.err ? 1 : 1 + cur.bus_cycles));
                        chk("bus_cycles", 32'(bus_run), 32'(cur.bus_cycles));
                        chk("misalign_err", 32'(misalign_err), 32'(cur.err));
                        chk("bus_err", 32'(bus_err), 32'(cur.timeout));
                        chk("rdata", rdata, cur.rdata);
                    end
                    bus_run   = 0;
                    stall_run = 0;
                end else begin
                    if (req_valid) stall_run++;
                    else chk("stall_idle", 32'(stall), 32'h0);
                    chk("misalign_err_quiet", 32'(misalign_err), 32'h0);
                    chk("bus_err_quiet", 32'(bus_err), 32'h0);
                end
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_bus_valid"}, 32'(mem.bus_valid), 32'h0);
        chk({tag, "_bus_we"}, 32'(mem.bus_we), 32'h0);
        chk({tag, "_bus_addr"}, mem.bus_addr, 32'h0);
        chk({tag, "_bus_wdata"}, mem.bus_wdata, 32'h0);
        chk({tag, "_bus_be"}, 32'(mem.bus_be), 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_misalign_err"}, 32'(misalign_err), 32'h0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    endtask

    initial begin
        slv_t s;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_values("reset");
        chk("reset_stall", 32'(stall), 32'h0);
        idle_gap(2);
        mon_en = 1'b1;

        // Directed cases: word load, byte store, misaligned half, illegal size, timeout, late ready
        issue(1'b0, 2'b10, 32'h0000_0100, 32'h1357_9BDF, 0, 32'hDEAD_BEEF);
        issue(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 0, 32'h0BAD_0BAD);
        issue(1'b0, 2'b01, 32'h0000_0101, 32'h0000_0000, 0, 32'h0);
        idle_gap(1);
        issue(1'b0, 2'b11, 32'h0000_0000, 32'h0000_0000, 0, 32'h0);
        issue(1'b0, 2'b10, 32'h0000_0400, 32'h0000_0000, int'(TIMEOUT) + 5, 32'h1111_2222);
        issue(1'b0, 2'b10, 32'h0000_0404, 32'h0000_0000, int'(TIMEOUT) - 1, 32'hCAFE_F00D);
        issue(1'b1, 2'b01, 32'h0000_0806, 32'h0000_BEEF, 2, 32'h0);
        idle_gap(2);

        for (int n = 0; n < 250; n++) begin
            logic [1:0] sz;
            int         cat;
            int         w;
            int         gap;
            cat = int'($urandom_range(0, 9));
            sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (cat < 6)      w = int'($urandom_range(0, 3));
            else if (cat < 8) w = int'($urandom_range(TIMEOUT - 2, TIMEOUT - 1));
            else              w = int'($urandom_range(TIMEOUT, TIMEOUT + 3));
            issue(1'($urandom_range(0, 1)), sz, $urandom, $urandom, w, $urandom);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle_gap(gap);
        end
        idle_gap(2);

        // Reset in the second BUS cycle of a store with three wait states
        mon_en = 1'b0;
        @(posedge clk); #1;
        s.waits = 3;
        s.rdata = 32'h0;
        slv_q.push_back(s);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0300;
        req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("rst_test_bus_valid_b1", 32'(mem.bus_valid), 32'h1);
        @(posedge clk); #1;
        chk("rst_test_bus_valid_b2", 32'(mem.bus_valid), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_values("bus_reset");
        chk("bus_reset_stall", 32'(stall), 32'h1);
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_bus_valid", 32'(mem.bus_valid), 32'h0);
            chk("post_reset_misalign_err", 32'(misalign_err), 32'h0);
            chk("post_reset_bus_err", 32'(bus_err), 32'h0);
        end
        @(posedge clk); #1;

        // After reset the interface must accept a fresh request from IDLE
        model_rdata = 32'h0;
        mon_en      = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 2'b00, 32'h0000_0502, 32'h0, 1, 32'h00C3_0000);
        idle_gap(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
